// File: rtl/add_seq_ctrl.sv
// Wide add/subtract sequencer that reuses one 32-bit adder stage, one word per cycle.
// Optional macro ADD_SEQ_OVF_EN adds a registered two's-complement overflow output (ovf).

module add_32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        c_i,
   output logic [31:0] s_o,
   output logic        c_o
);
   assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {32'b0, c_i};
endmodule

module add_seq_ctrl #(
   parameter int WORDS = 4,
   parameter int IDXW  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_valid,
   output logic                 start_ready,
   input  logic [WORDS*32-1:0]  op_a,
   input  logic [WORDS*32-1:0]  op_b,
   input  logic                 sub,
   input  logic                 cin,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [WORDS*32-1:0]  sum,
   output logic                 cout
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic                 ovf
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]             state_q, state_d;
   logic [IDXW-1:0]        idx_q, idx_d;
   logic [WORDS-1:0][31:0] aReg_q, aReg_d;
   logic [WORDS-1:0][31:0] bReg_q, bReg_d;
   logic [WORDS-1:0][31:0] sum_q, sum_d;
   logic                   carry_q, carry_d;
   logic                   cout_q, cout_d;
   logic                   resValid_q, resValid_d;
`ifdef ADD_SEQ_OVF_EN
   logic                   ovf_q, ovf_d;
   logic                   msbCarryIn;
`endif

   logic [31:0] aWord, bWord, addSum;
   logic        addCarry;
   logic        lastWord;

   // Adder inputs come only from registers, selected by the word index.
   always_comb begin
      aWord = '0;
      bWord = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (idx_q == IDXW'(w)) begin
            aWord = aReg_q[w];
            bWord = bReg_q[w];
         end
      end
   end

   add_32 u_add (
      .a_i (aWord),
      .b_i (bWord),
      .c_i (carry_q),
      .s_o (addSum),
      .c_o (addCarry)
   );

   assign lastWord = (idx_q == IDXW'(WORDS - 1));
`ifdef ADD_SEQ_OVF_EN
   assign msbCarryIn = addSum[31] ^ aWord[31] ^ bWord[31];
`endif

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      aReg_d     = aReg_q;
      bReg_d     = bReg_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      cout_d     = cout_q;
      resValid_d = resValid_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d      = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               aReg_d  = op_a;
               // Subtraction is A + ~B + 1.
               bReg_d  = sub ? ~op_b : op_b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int w = 0; w < WORDS; w++) begin
               if (idx_q == IDXW'(w)) begin
                  sum_d[w] = addSum;
               end
            end
            carry_d = addCarry;
            if (lastWord) begin
               cout_d     = addCarry;
`ifdef ADD_SEQ_OVF_EN
               ovf_d      = msbCarryIn ^ addCarry;
`endif
               resValid_d = 1'b1;
               state_d    = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (res_ready) begin
               resValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         aReg_q     <= '0;
         bReg_q     <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         cout_q     <= 1'b0;
         resValid_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         aReg_q     <= aReg_d;
         bReg_q     <= bReg_d;
         sum_q      <= sum_d;
         carry_q    <= carry_d;
         cout_q     <= cout_d;
         resValid_q <= resValid_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign start_ready = (state_q == IDLE);
   assign res_valid   = resValid_q;
   assign sum         = sum_q;
   assign cout        = cout_q;
`ifdef ADD_SEQ_OVF_EN
   assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (WORDS=4), with extra checks when ADD_SEQ_OVF_EN is defined.

module tb_add_seq_ctrl;

   localparam int WORDS = 4;
   localparam int W     = WORDS * 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a, op_b;
   logic         sub, cin;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] sum;
   logic         cout;
`ifdef ADD_SEQ_OVF_EN
   logic         ovf;
`endif

   int compared   = 0;
   int mismatched = 0;

   add_seq_ctrl #(.WORDS(WORDS), .IDXW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .sub         (sub),
      .cin         (cin),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .sum         (sum),
      .cout        (cout)
`ifdef ADD_SEQ_OVF_EN
      ,
      .ovf         (ovf)
`endif
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one request, waits for the accept edge, scrambles the operand ports
   // afterwards, and returns how many edges later res_valid rose (capped at 20).
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c, output int latency);
      int waitCycles;
      op_a = a; op_b = b; sub = s; cin = c;
      start_valid = 1'b1;
      waitCycles = 0;
      while (!start_ready && waitCycles < 20) begin
         @(posedge clk); #1;
         waitCycles++;
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      op_a = {WORDS{32'hDEAD_BEEF}};
      op_b = {WORDS{32'h1357_9BDF}};
      sub  = ~s;
      cin  = ~c;
      latency = 0;
      do begin
         @(posedge clk); #1;
         latency++;
      end while (!res_valid && latency < 20);
   endtask

   task automatic handOff();
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   logic [W-1:0] heldSum;
   logic         heldCout;
   int           lat;
   int           stableBad;
   int           sawValid;

   initial begin
      rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
      op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_start_ready", W'(start_ready), W'(1));
      checkOutput("reset_res_valid",   W'(res_valid),   W'(0));
      checkOutput("reset_sum",         sum,             '0);
      checkOutput("reset_cout",        W'(cout),        W'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] carry chain");
      applyStimulus(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, lat);
      checkOutput("carry_latency", W'(lat), W'(4));
      checkOutput("carry_sum",  sum, 128'h0000_0001_0000_0000_0000_0000_0000_0000);
      checkOutput("carry_cout", W'(cout), W'(0));
      handOff();

      $display("[TB] full wrap");
      applyStimulus({W{1'b1}}, '0, 1'b0, 1'b1, lat);
      checkOutput("wrap_valid", W'(res_valid), W'(1));
      checkOutput("wrap_sum",  sum, '0);
      checkOutput("wrap_cout", W'(cout), W'(1));
      handOff();

      $display("[TB] subtract with borrow");
      applyStimulus(128'h5, 128'h7, 1'b1, 1'b1, lat);
      checkOutput("subb_latency", W'(lat), W'(4));
      checkOutput("subb_sum",  sum, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);
      checkOutput("subb_cout", W'(cout), W'(0));
      handOff();

      $display("[TB] subtract without borrow");
      applyStimulus(128'h7, 128'h5, 1'b1, 1'b0, lat);
      checkOutput("sub_sum",  sum, 128'h2);
      checkOutput("sub_cout", W'(cout), W'(1));
      handOff();

      $display("[TB] backpressure");
      applyStimulus(128'h1234_5678_0000_0000_FFFF_0000_0000_1234, 128'h1, 1'b0, 1'b0, lat);
      checkOutput("bp_sum", sum, 128'h1234_5678_0000_0000_FFFF_0000_0000_1235);
      heldSum  = sum;
      heldCout = cout;
      op_a = 128'd100; op_b = 128'd50; sub = 1'b1; cin = 1'b0;
      start_valid = 1'b1;
      stableBad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (sum !== heldSum || cout !== heldCout || res_valid !== 1'b1 || start_ready !== 1'b0)
            stableBad++;
      end
      checkOutput("bp_hold_stable", W'(stableBad), W'(0));
      handOff();
      checkOutput("bp_release_valid", W'(res_valid),   W'(0));
      checkOutput("bp_release_ready", W'(start_ready), W'(1));
      @(posedge clk); #1;
      start_valid = 1'b0;
      checkOutput("bp_queued_accepted", W'(start_ready), W'(0));
      checkOutput("bp_sum_kept_on_accept", sum, heldSum);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!res_valid && lat < 20);
      checkOutput("queued_latency", W'(lat), W'(4));
      checkOutput("queued_sum",  sum, 128'd50);
      checkOutput("queued_cout", W'(cout), W'(1));
      handOff();

      $display("[TB] reset mid-operation");
      @(posedge clk); #1;
      op_a = {W{1'b1}}; op_b = 128'h1; sub = 1'b0; cin = 1'b0;
      start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("rst_mid_start_ready", W'(start_ready), W'(1));
      checkOutput("rst_mid_sum",  sum, '0);
      checkOutput("rst_mid_cout", W'(cout), W'(0));
      sawValid = 0;
      for (int i = 0; i < 8; i++) begin
         if (res_valid !== 1'b0) sawValid++;
         @(posedge clk); #1;
      end
      checkOutput("rst_mid_no_valid", W'(sawValid), W'(0));

`ifdef ADD_SEQ_OVF_EN
      $display("[TB] overflow");
      applyStimulus(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, lat);
      checkOutput("ovf_pos_sum",  sum, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
      checkOutput("ovf_pos_ovf",  W'(ovf),  W'(1));
      checkOutput("ovf_pos_cout", W'(cout), W'(0));
      handOff();
      applyStimulus({W{1'b1}}, 128'h1, 1'b0, 1'b0, lat);
      checkOutput("ovf_neg_ovf",  W'(ovf),  W'(0));
      checkOutput("ovf_neg_cout", W'(cout), W'(1));
      handOff();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
